hid_inject_arbiter: RTL and testbench

Parametrised successor to the fixed keyboard/mouse injection mux. It merges one stream of live HID reports from the upstream USB host path with reports injected from the SAMD51 command path, for any report width. Injected reports are buffered in a FIFO, and the output uses a valid/ready handshake so the USB device-side packetiser can apply backpressure. Auto-release is configurable, and a newer injection can cancel a pending release. One instance sits per HID endpoint, between the host-side report extractor and the device-side IN packetiser.

---
 rtl/hid_inject_arbiter_if.sv | 16 +
 rtl/hid_inject_arbiter.sv | 89 ++++++++
 tb/tb_hid_inject_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hid_inject_arbiter_if.sv
// hid_inject_arbiter_if: live host, injected and merged report streams with their handshakes
interface hid_inject_arbiter_if #(parameter int RPT_W = 64);
   logic [RPT_W-1:0] host_report;
   logic             host_valid;
   logic             host_drop;
   logic [RPT_W-1:0] inj_report;
   logic             inj_valid;
   logic             inj_ready;
   logic [RPT_W-1:0] out_report;
   logic             out_valid;
   logic             out_ready;
   modport master (output host_report, host_valid, inj_report, inj_valid, out_ready,
                   input host_drop, inj_ready, out_report, out_valid);
   modport slave (input host_report, host_valid, inj_report, inj_valid, out_ready,
                  output host_drop, inj_ready, out_report, out_valid);
endinterface

// File: rtl/hid_inject_arbiter.sv
// hid_inject_arbiter: merges live host HID reports with FIFO-buffered injections and auto-release.
// Define INJECT_STATS_EN to build the saturating inj_count/drop_count counters.
module hid_inject_arbiter #(
   parameter int               RPT_W       = 64,
   parameter int               FIFO_DEPTH  = 4,
   parameter int               RELEASE_DLY = 6000,
   parameter logic [RPT_W-1:0] PRESS_MASK  = {RPT_W{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hid_inject_arbiter_if.slave  bus,
   output logic [15:0]          inj_count,
   output logic [15:0]          drop_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = RELEASE_DLY > 1 ? $clog2(RELEASE_DLY + 1) : 1;
   typedef enum logic [2:0] {IDLE, OUT_INJ, WAIT_REL, OUT_REL, OUT_HOST} state_t;
   state_t           state, state_nx;
   logic [RPT_W-1:0] fifo [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [RPT_W-1:0] hold;
   logic             hold_vld;
   logic [TW-1:0]    tmr;
   logic             empty, full, push, pop, hs, tmr_zero, press, take_host, drop_nx;
   assign empty         = wr_ptr == rd_ptr;
   assign full          = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
   assign push          = bus.inj_valid && !full;
   assign bus.inj_ready = !full;
   assign hs            = bus.out_valid && bus.out_ready;
   assign tmr_zero      = tmr == '0;
   assign press         = |(bus.out_report & PRESS_MASK) && RELEASE_DLY != 0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = !empty ? OUT_INJ : hold_vld ? OUT_HOST : IDLE;
         WAIT_REL: state_nx = !empty ? OUT_INJ : tmr_zero ? OUT_REL : WAIT_REL;
         OUT_INJ:  if (hs) state_nx = press ? WAIT_REL : IDLE;
         default:  if (hs) state_nx = IDLE;
      endcase
   end
   // A held host report is never selected while a release is pending; it waits for IDLE.
   always_comb begin
      bus.out_valid = state == OUT_INJ || state == OUT_REL || state == OUT_HOST;
      pop           = (state == IDLE || state == WAIT_REL) && !empty;
      take_host     = state == IDLE && empty && hold_vld;
      drop_nx       = bus.host_valid && (state == WAIT_REL || (hold_vld && !take_host));
   end
   always_ff @(posedge clk)
      if (push) fifo[wr_ptr[AW-1:0]] <= bus.inj_report;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         hold           <= '0;
         hold_vld       <= 1'b0;
         tmr            <= '0;
         bus.out_report <= '0;
         bus.host_drop  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (bus.host_valid && state != WAIT_REL) begin
            hold     <= bus.host_report;
            hold_vld <= 1'b1;
         end else if (take_host) hold_vld <= 1'b0;
         bus.host_drop <= drop_nx;
         if (state == OUT_INJ && hs && press) tmr <= TW'(RELEASE_DLY);
         else if (state == WAIT_REL && !tmr_zero) tmr <= tmr - 1'b1;
         if (pop) bus.out_report <= fifo[rd_ptr[AW-1:0]];
         else if (state == WAIT_REL && tmr_zero) bus.out_report <= '0;
         else if (take_host) bus.out_report <= hold;
      end
`ifdef INJECT_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         inj_count  <= '0;
         drop_count <= '0;
      end else begin
         if (state == OUT_INJ && hs && inj_count != 16'hFFFF) inj_count <= inj_count + 1'b1;
         if (bus.host_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
`else
   assign inj_count  = '0;
   assign drop_count = '0;
`endif
endmodule

// File: tb/tb_hid_inject_arbiter.sv
// tb_hid_inject_arbiter: directed checks of host path, injection FIFO, auto-release and reset.
module tb_hid_inject_arbiter;
   localparam int W = 64;
   localparam int DLY = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] inj_count, drop_count;
   int tests = 0;
   int fails = 0;
   logic [W-1:0] rpts [4];
   logic any_v, seen;
   hid_inject_arbiter_if #(.RPT_W(W)) bus ();
   hid_inject_arbiter #(.RPT_W(W), .FIFO_DEPTH(4), .RELEASE_DLY(DLY)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .inj_count(inj_count), .drop_count(drop_count));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.host_report = '0;
      bus.host_valid  = 1'b0;
      bus.inj_report  = '0;
      bus.inj_valid   = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_report", bus.out_report, 0);
      chk("rst_inj_ready", bus.inj_ready, 1);
      chk("rst_host_drop", bus.host_drop, 0);
      chk("rst_inj_count", inj_count, 0);
      chk("rst_drop_count", drop_count, 0);
      rst_n = 1'b1;
      step();
      // host report: visible two edges after the strobe, for one cycle
      bus.host_report = 64'h11;
      bus.host_valid  = 1'b1;
      step();
      bus.host_valid = 1'b0;
      chk("host_lat_e0", bus.out_valid, 0);
      step();
      chk("host_valid", bus.out_valid, 1);
      chk("host_report", bus.out_report, 64'h11);
      step();
      chk("host_one_cycle", bus.out_valid, 0);
      // injected press, release 17 edges after its handshake, host drops in between
      bus.inj_report = 64'h0000_0004_0000_0000;
      bus.inj_valid  = 1'b1;
      step();
      bus.inj_valid = 1'b0;
      step();
      chk("press_valid", bus.out_valid, 1);
      chk("press_report", bus.out_report, 64'h0000_0004_0000_0000);
      step();
      chk("press_done", bus.out_valid, 0);
      bus.host_report = 64'h55;
      bus.host_valid  = 1'b1;
      step();
      bus.host_valid = 1'b0;
      chk("wait_drop_pulse", bus.host_drop, 1);
      step();
      chk("wait_drop_single", bus.host_drop, 0);
      any_v = 1'b0;
      repeat (DLY - 2) begin
         step();
         any_v |= bus.out_valid;
      end
      chk("rel_not_early", any_v, 0);
      step();
      chk("rel_valid", bus.out_valid, 1);
      chk("rel_report", bus.out_report, 0);
      step();
      chk("rel_done", bus.out_valid, 0);
      step();
      chk("wait_host_discarded", bus.out_valid, 0);
      // stall on a host report, fill the FIFO, then drain in order
      bus.out_ready   = 1'b0;
      bus.host_report = 64'h22;
      bus.host_valid  = 1'b1;
      step();
      bus.host_valid = 1'b0;
      step();
      chk("stall_host_valid", bus.out_valid, 1);
      rpts[0] = 64'h101; rpts[1] = 64'h202; rpts[2] = 64'h303; rpts[3] = 64'h404;
      for (int i = 0; i < 4; i++) begin
         bus.inj_report = rpts[i];
         bus.inj_valid  = 1'b1;
         step();
         chk("fill_inj_ready", bus.inj_ready, (i < 3) ? 1 : 0);
      end
      bus.inj_report = 64'h505;
      step();
      bus.inj_valid = 1'b0;
      chk("full_inj_ready", bus.inj_ready, 0);
      chk("stall_stable", bus.out_report, 64'h22);
      bus.out_ready = 1'b1;
      step();
      chk("stall_host_done", bus.out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_valid", bus.out_valid, 1);
         chk("drain_report", bus.out_report, rpts[i]);
         step();
         chk("drain_gap", bus.out_valid, 0);
      end
      chk("drain_inj_ready", bus.inj_ready, 1);
      any_v = 1'b0;
      repeat (DLY) begin
         step();
         any_v |= bus.out_valid;
      end
      chk("no_fifth_report", any_v, 0);
      step();
      chk("drain_rel_report", bus.out_report, 0);
      chk("drain_rel_valid", bus.out_valid, 1);
      step();
      // press A, press B a few cycles later: single release 17 edges after B
      bus.inj_report = 64'h1000;
      bus.inj_valid  = 1'b1;
      step();
      bus.inj_valid = 1'b0;
      step();
      chk("press_a", bus.out_report, 64'h1000);
      step();
      repeat (3) step();
      bus.inj_report = 64'h2000;
      bus.inj_valid  = 1'b1;
      step();
      bus.inj_valid = 1'b0;
      step();
      chk("press_b_valid", bus.out_valid, 1);
      chk("press_b", bus.out_report, 64'h2000);
      step();
      any_v = 1'b0;
      repeat (DLY) begin
         step();
         any_v |= bus.out_valid;
      end
      chk("ab_cancelled", any_v, 0);
      step();
      chk("ab_rel_valid", bus.out_valid, 1);
      chk("ab_rel_report", bus.out_report, 0);
      any_v = 1'b0;
      repeat (2 * DLY) begin
         step();
         any_v |= bus.out_valid;
      end
      chk("ab_single_rel", any_v, 0);
      // reset during a pending release
      bus.inj_report = 64'h4000;
      bus.inj_valid  = 1'b1;
      step();
      bus.inj_valid = 1'b0;
      step();
      step();
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_report", bus.out_report, 0);
      chk("mid_rst_inj_ready", bus.inj_ready, 1);
      chk("mid_rst_drop", bus.host_drop, 0);
      step();
      rst_n = 1'b1;
      any_v = 1'b0;
      repeat (2 * DLY + 4) begin
         step();
         any_v |= bus.out_valid;
      end
      chk("no_rel_after_rst", any_v, 0);
      // stats: three injections, two overwritten host reports
      bus.out_ready   = 1'b0;
      bus.host_valid  = 1'b1;
      bus.host_report = 64'h31;
      step();
      bus.host_report = 64'h32;
      step();
      chk("ovr_no_drop", bus.host_drop, 0);
      bus.host_report = 64'h33;
      step();
      chk("ovr_drop1", bus.host_drop, 1);
      bus.host_report = 64'h34;
      step();
      chk("ovr_drop2", bus.host_drop, 1);
      bus.host_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.inj_report = 64'h700 + 64'(i);
         bus.inj_valid  = 1'b1;
         step();
      end
      bus.inj_valid = 1'b0;
      bus.out_ready = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         step();
         if (bus.out_valid && bus.out_report == 64'h34) seen = 1'b1;
      end
      chk("latest_host_wins", seen, 1);
`ifdef INJECT_STATS_EN
      chk("inj_count", inj_count, 3);
      chk("drop_count", drop_count, 2);
`else
      chk("inj_count_tied", inj_count, 0);
      chk("drop_count_tied", drop_count, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
